// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
// The JALR state exists only when CTRL_JALR_EN is defined.
package rv_ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b1000;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResMemData = 2'b01;
    localparam logic [1:0] ResAlu     = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseBus     = 2'b10;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
`ifdef CTRL_JALR_EN
        StJalr,
`endif
        StTrap
    } state_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction fields, datapath flags and control strobes between the control unit
// (master) and the shared datapath/memory (slave).
interface multicycle_control_if #(
    parameter int unsigned ALUCTRL_W = 4
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 mem_ready;

    logic                 mem_req;
    logic                 mem_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [2:0]           imm_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 trap;
    logic [1:0]           trap_cause;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control, trap, trap_cause
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control, trap, trap_cause
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive unanswered memory-request cycles and flags a bus timeout.
// WAIT_LIMIT of 0 disables the timeout entirely.
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    if (WAIT_LIMIT == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst, req, ready};
        assign timeout       = 1'b0;
    end else begin : g_on
        localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);

        logic [CntW-1:0] cnt_q;

        // The FSM only leaves a requesting state on ready or into TRAP (no request),
        // so clearing whenever the cycle is not a pure wait also covers state changes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (req && !ready) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end

        // Fires on the wait cycle that would bring the count to the limit; ready wins.
        assign timeout = req && !ready && (cnt_q == CntW'(WAIT_LIMIT - 1));
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback with bus timeout
// and illegal-opcode trap. Define CTRL_JALR_EN to make opcode 1100111 legal.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned ALUCTRL_W  = 4
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master bus
);

    state_e               state_q;
    logic [1:0]           cause_q;
    logic                 timeout;

    logic                 mem_req;
    logic                 mem_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [2:0]           imm_src;
    logic [ALUCTRL_W-1:0] alu_control;

    mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .req    (mem_req),
        .ready  (bus.mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cause_q <= CauseNone;
        end else begin
            case (state_q)
                StFetch: begin
                    if (bus.mem_ready) begin
                        state_q <= StDecode;
                    end else if (timeout) begin
                        state_q <= StTrap;
                        cause_q <= CauseBus;
                    end
                end
                StDecode: begin
                    case (bus.op)
                        OpLoad, OpStore: state_q <= StMemAdr;
                        OpRtype:         state_q <= StExecR;
                        OpItype:         state_q <= StExecI;
                        OpBranch:        state_q <= StBranch;
                        OpJal:           state_q <= StJal;
`ifdef CTRL_JALR_EN
                        OpJalr:          state_q <= StJalr;
`endif
                        default: begin
                            state_q <= StTrap;
                            cause_q <= CauseIllegal;
                        end
                    endcase
                end
                StMemAdr: state_q <= (bus.op == OpStore) ? StMemWrite : StMemRead;
                StMemRead: begin
                    if (bus.mem_ready) begin
                        state_q <= StMemWb;
                    end else if (timeout) begin
                        state_q <= StTrap;
                        cause_q <= CauseBus;
                    end
                end
                StMemWrite: begin
                    if (bus.mem_ready) begin
                        state_q <= StFetch;
                    end else if (timeout) begin
                        state_q <= StTrap;
                        cause_q <= CauseBus;
                    end
                end
                StMemWb, StAluWb:  state_q <= StFetch;
                StExecR, StExecI:  state_q <= StAluWb;
                StBranch: begin
                    if (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) begin
                        state_q <= StFetch;
                    end else begin
                        state_q <= StTrap;
                        cause_q <= CauseIllegal;
                    end
                end
                StJal:             state_q <= StAluWb;
`ifdef CTRL_JALR_EN
                StJalr:            state_q <= StAluWb;
`endif
                default:           state_q <= StTrap;
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SrcAPc;
        alu_src_b   = SrcBRs2;
        result_src  = ResAluOut;
        imm_src     = ImmI;
        alu_control = ALUCTRL_W'(AluAdd);
        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                imm_src   = ImmB;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                imm_src   = (bus.op == OpStore) ? ImmS : ImmI;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = ResMemData;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            StExecR: begin
                alu_src_a   = SrcARs1;
                alu_control = ALUCTRL_W'({bus.funct7b5, bus.funct3});
            end
            StExecI: begin
                alu_src_a   = SrcARs1;
                alu_src_b   = SrcBImm;
                // Only SRAI/SRLI use bit 30; ADDI etc. must not turn into SUB.
                alu_control = ALUCTRL_W'({bus.funct7b5 & (bus.funct3 == 3'b101), bus.funct3});
            end
            StAluWb: begin
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a   = SrcARs1;
                imm_src     = ImmB;
                alu_control = ALUCTRL_W'(AluSub);
                pc_write    = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                              ((bus.funct3 == 3'b001) && !bus.zero);
            end
            StJal: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                imm_src   = ImmJ;
                pc_write  = 1'b1;
            end
`ifdef CTRL_JALR_EN
            StJalr: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBImm;
                result_src = ResAlu;
                pc_write   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Strobes are gated by reset so an in-flight access dies the moment rst rises.
    assign bus.mem_req     = mem_req & ~rst;
    assign bus.mem_write   = mem_write & ~rst;
    assign bus.ir_write    = ir_write & ~rst;
    assign bus.pc_write    = pc_write & ~rst;
    assign bus.reg_write   = reg_write & ~rst;
    assign bus.adr_src     = adr_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.result_src  = result_src;
    assign bus.imm_src     = imm_src;
    assign bus.alu_control = alu_control;
    assign bus.trap        = (state_q == StTrap);
    assign bus.trap_cause  = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors are queued
// with their stimulus, then popped and compared as the DUT steps through each state.
`timescale 1ns/1ps
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALUCTRL_W(4)) bus ();
    multicycle_control_if #(.ALUCTRL_W(4)) bus4 ();
    multicycle_control_if #(.ALUCTRL_W(4)) bus0 ();

    multicycle_control #(.WAIT_LIMIT(16), .ALUCTRL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    multicycle_control #(.WAIT_LIMIT(4), .ALUCTRL_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    multicycle_control #(.WAIT_LIMIT(0), .ALUCTRL_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Vector: req wr adr irw pcw rw | a[1:0] b[1:0] rs[1:0] imm[2:0] alu[3:0] | trap cause[1:0]
    localparam logic [21:0] MaskStb = 22'h3F0007;
    localparam logic [21:0] MaskA   = 22'h00C000;
    localparam logic [21:0] MaskB   = 22'h003000;
    localparam logic [21:0] MaskRs  = 22'h000C00;
    localparam logic [21:0] MaskImm = 22'h000380;
    localparam logic [21:0] MaskAlu = 22'h000078;

    typedef struct {
        string       name;
        logic        ready;
        logic        zero;
        logic [21:0] val;
        logic [21:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [21:0] obs();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src,
                bus.alu_control, bus.trap, bus.trap_cause};
    endfunction

    function automatic logic [21:0] mk(input logic req, wr, adr, irw, pcw, rw,
                                       input logic [1:0] a, b, rs, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic trp,
                                       input logic [1:0] cause);
        return {req, wr, adr, irw, pcw, rw, a, b, rs, imm, alu, trp, cause};
    endfunction

    task automatic push(input string name, input logic ready, input logic zero,
                        input logic [21:0] val, input logic [21:0] mask);
        exp_t x;
        x.name = name; x.ready = ready; x.zero = zero; x.val = val; x.mask = mask;
        sb.push_back(x);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7b5;
    endtask

    task automatic exp_fetch(input logic ready);
        push("fetch", ready, 1'b0, mk(1, 0, 0, ready, ready, 0, 2'b00, 2'b10, 2'b10, 3'b000,
             4'b0000, 0, 2'b00), MaskStb | MaskA | MaskB | MaskRs);
    endtask

    // mem_ready held high in DECODE to show it is ignored outside memory states.
    task automatic exp_decode();
        push("decode", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010,
             4'b0000, 0, 2'b00), MaskStb | MaskA | MaskB | MaskImm);
    endtask

    task automatic exp_aluwb();
        push("aluwb", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000,
             4'b0000, 0, 2'b00), MaskStb | MaskRs);
    endtask

    // Leaves rst deasserted at posedge+1, i.e. inside the first post-reset cycle.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ((obs() & MaskStb) !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %h want 000000 (masked %h)", obs(), MaskStb);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_req, bus.ir_write, bus.trap, bus.trap_cause} !== 5'b10000) begin
            n_fail++;
            $display("FAIL first_cycle_req: got %b want 10000",
                     {bus.mem_req, bus.ir_write, bus.trap, bus.trap_cause});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_ops();
        logic [3:0] f7f3 [4] = '{4'b0000, 4'b1000, 4'b1101, 4'b1000};
        logic [6:0] ops  [4] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
        logic [3:0] alu  [4] = '{4'b0000, 4'b1000, 4'b1101, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            set_instr(ops[i], f7f3[i][2:0], f7f3[i][3]);
            exp_fetch(1'b1);
            exp_decode();
            if (ops[i] == 7'b0110011)
                push("exec_r", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000,
                     alu[i], 0, 2'b00), MaskStb | MaskA | MaskB | MaskAlu);
            else
                push("exec_i", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000,
                     alu[i], 0, 2'b00), MaskStb | MaskA | MaskB | MaskImm | MaskAlu);
            exp_aluwb();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                bus.mem_ready = e.ready; bus.zero = e.zero;
                @(negedge clk);
                n_checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    n_fail++;
                    $display("FAIL alu_%s[%0d]: got %h want %h mask %h", e.name, i, obs(),
                             e.val, e.mask);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load_wait();
        set_instr(7'b0000011, 3'b010, 1'b0);
        exp_fetch(1'b1);
        exp_decode();
        push("memadr_ld", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000,
             4'b0000, 0, 2'b00), MaskStb | MaskA | MaskB | MaskImm | MaskAlu);
        for (int i = 0; i < 3; i++)
            push("memread_wait", 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,
                 4'b0000, 0, 2'b00), MaskStb);
        push("memread_done", 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,
             4'b0000, 0, 2'b00), MaskStb);
        push("memwb", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000,
             4'b0000, 0, 2'b00), MaskStb | MaskRs);
        exp_fetch(1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.mem_ready = e.ready; bus.zero = e.zero;
            @(negedge clk);
            n_checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL load_%s: got %h want %h mask %h", e.name, obs(), e.val, e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        set_instr(7'b0100011, 3'b010, 1'b0);
        exp_fetch(1'b1);
        exp_decode();
        push("memadr_st", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001,
             4'b0000, 0, 2'b00), MaskStb | MaskA | MaskB | MaskImm | MaskAlu);
        push("memwrite", 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,
             4'b0000, 0, 2'b00), MaskStb);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.mem_ready = e.ready; bus.zero = e.zero;
            @(negedge clk);
            n_checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL store_%s: got %h want %h mask %h", e.name, obs(), e.val, e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3  [4] = '{3'b000, 3'b001, 3'b001, 3'b000};
        logic       zf  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       pcw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_instr(7'b1100011, f3[i], 1'b0);
            exp_fetch(1'b1);
            exp_decode();
            push("branch", 1'b1, zf[i], mk(0, 0, 0, 0, pcw[i], 0, 2'b10, 2'b00, 2'b00, 3'b000,
                 4'b1000, 0, 2'b00), MaskStb | MaskA | MaskB | MaskRs | MaskAlu);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                bus.mem_ready = e.ready; bus.zero = e.zero;
                @(negedge clk);
                n_checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    n_fail++;
                    $display("FAIL branch_%s[%0d]: got %h want %h mask %h", e.name, i, obs(),
                             e.val, e.mask);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jumps();
        set_instr(7'b1101111, 3'b000, 1'b0);
        exp_fetch(1'b1);
        exp_decode();
        push("jal", 1'b1, 1'b0, mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000,
             0, 2'b00), MaskStb | MaskA | MaskB | MaskRs);
        exp_aluwb();
`ifdef CTRL_JALR_EN
        push("jalr_op", 1'b1, 1'b0, 22'h0, 22'h0);
        exp_fetch(1'b1);
        exp_decode();
        push("jalr", 1'b1, 1'b0, mk(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000,
             0, 2'b00), MaskStb | MaskA | MaskB | MaskRs | MaskImm);
        exp_aluwb();
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.name == "jalr_op") begin
                set_instr(7'b1100111, 3'b000, 1'b0);
                continue;
            end
            bus.mem_ready = e.ready; bus.zero = e.zero;
            @(negedge clk);
            n_checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL jump_%s: got %h want %h mask %h", e.name, obs(), e.val, e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        bus4.op = 7'b0110011; bus4.funct3 = 3'b000; bus4.funct7b5 = 1'b0; bus4.zero = 1'b0;
        bus0.op = 7'b0110011; bus0.funct3 = 3'b000; bus0.funct7b5 = 1'b0; bus0.zero = 1'b0;
        bus0.mem_ready = 1'b0;
        // Ready arriving on the cycle the count would reach the limit must win.
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            bus4.mem_ready = (c == 4);
            @(negedge clk);
            n_checks++;
            if (c <= 4 && {bus4.mem_req, bus4.ir_write, bus4.trap} !== {1'b1, c == 4, 1'b0}) begin
                n_fail++;
                $display("FAIL ready_wins_c%0d: got %b want %b", c,
                         {bus4.mem_req, bus4.ir_write, bus4.trap}, {1'b1, c == 4, 1'b0});
            end else if (c == 5 && {bus4.mem_req, bus4.trap} !== 2'b00) begin
                n_fail++;
                $display("FAIL ready_wins_decode: got %b want 00", {bus4.mem_req, bus4.trap});
            end
            @(posedge clk); #1;
        end
        do_reset();
        bus4.mem_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (c <= 4 && {bus4.mem_req, bus4.trap, bus4.trap_cause} !== 4'b1000) begin
                n_fail++;
                $display("FAIL timeout_wait_c%0d: got %b want 1000", c,
                         {bus4.mem_req, bus4.trap, bus4.trap_cause});
            end else if (c > 4 && {bus4.mem_req, bus4.trap, bus4.trap_cause} !== 4'b0110) begin
                n_fail++;
                $display("FAIL timeout_trap_c%0d: got %b want 0110", c,
                         {bus4.mem_req, bus4.trap, bus4.trap_cause});
            end
            @(posedge clk); #1;
        end
        repeat (30) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({bus0.mem_req, bus0.trap, bus0.trap_cause} !== 4'b1000) begin
            n_fail++;
            $display("FAIL no_timeout_limit0: got %b want 1000",
                     {bus0.mem_req, bus0.trap, bus0.trap_cause});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        set_instr(7'b0100011, 3'b010, 1'b0);
        exp_fetch(1'b1);
        exp_decode();
        push("memadr", 1'b1, 1'b0, 22'h0, MaskStb);
        push("memwrite_wait", 1'b0, 1'b0, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,
             4'b0000, 0, 2'b00), MaskStb);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.mem_ready = e.ready; bus.zero = e.zero;
            @(negedge clk);
            n_checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL midwr_%s: got %h want %h mask %h", e.name, obs(), e.val, e.mask);
            end
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_write, bus.mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL midwr_drop: got %b want 00", {bus.mem_write, bus.mem_req});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        exp_fetch(1'b1);
        exp_decode();
        push("exec_r", 1'b1, 1'b0, 22'h0, MaskStb);
        exp_aluwb();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.mem_ready = e.ready; bus.zero = e.zero;
            @(negedge clk);
            n_checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL restart_%s: got %h want %h mask %h", e.name, obs(), e.val,
                         e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3] = '{7'b0000000, 7'b1100011, 7'b1100111};
        logic [2:0] f3  [3] = '{3'b000, 3'b100, 3'b000};
        int n_cases;
`ifdef CTRL_JALR_EN
        n_cases = 2;
`else
        n_cases = 3;
`endif
        for (int i = 0; i < n_cases; i++) begin
            do_reset();
            set_instr(ops[i], f3[i], 1'b0);
            exp_fetch(1'b1);
            exp_decode();
            if (ops[i] == 7'b1100011)
                push("bad_branch", 1'b1, 1'b1, 22'h0, MaskStb);
            for (int k = 0; k < 20; k++)
                push("trap_hold", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00,
                     3'b000, 4'b0000, 1, 2'b01), MaskStb);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                bus.mem_ready = e.ready; bus.zero = e.zero;
                @(negedge clk);
                n_checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    n_fail++;
                    $display("FAIL illegal_%s[%0d]: got %h want %h mask %h", e.name, i, obs(),
                             e.val, e.mask);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        set_instr(7'b0110011, 3'b000, 1'b0);
        bus.zero = 1'b0;   bus.mem_ready = 1'b0;
        bus4.op = 7'b0110011; bus4.funct3 = 3'b000; bus4.funct7b5 = 1'b0;
        bus4.zero = 1'b0;  bus4.mem_ready = 1'b0;
        bus0.op = 7'b0110011; bus0.funct3 = 3'b000; bus0.funct7b5 = 1'b0;
        bus0.zero = 1'b0;  bus0.mem_ready = 1'b0;
        test_reset();
        test_alu_ops();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps();
        test_timeout();
        test_reset_midwrite();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
